tick_prescaler_mc: RTL and testbench

//  Multi-channel programmable tick generator; parametrised successor of the fixed single-divisor time converter.

---
 rtl/tick_prescaler_mc.sv | 176 +++++++++++++++++
 tb/tb_tick_prescaler_mc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_prescaler_mc.sv
// tick_prescaler_mc: multi-channel programmable tick generator.
// Each channel divides clk by a runtime-loadable divisor and runs either
// periodic (free-running) or one-shot (single tick, then hold done).
// Optional feature macro: TICK_PRESCALER_SQ_OUT_EN adds a registered
// square-wave output sq that toggles on every tick.
module tick_prescaler_mc #(
    parameter int CNT_W       = 24,
    parameter int NUM_CH      = 2,
    parameter int DEFAULT_DIV = 2500000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_oneshot,
`ifdef TICK_PRESCALER_SQ_OUT_EN
    output logic [NUM_CH-1:0] sq,
`endif
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    // Terminal count of a period; divisor 0 behaves like divisor 1.
    function automatic logic [CNT_W-1:0] last_cnt(input logic [CNT_W-1:0] div);
        if (div == {CNT_W{1'b0}}) begin
            return {CNT_W{1'b0}};
        end else begin
            return div - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    logic [1:0]       state_q   [NUM_CH];
    logic [1:0]       state_d   [NUM_CH];
    logic [CNT_W-1:0] cnt_q     [NUM_CH];
    logic [CNT_W-1:0] cnt_d     [NUM_CH];
    logic [CNT_W-1:0] div_act_q [NUM_CH];
    logic [CNT_W-1:0] div_act_d [NUM_CH];
    logic [CNT_W-1:0] div_shd_q [NUM_CH];
    logic [CNT_W-1:0] div_shd_d [NUM_CH];
    logic [CNT_W-1:0] new_div_s [NUM_CH];
    logic             os_act_q  [NUM_CH];
    logic             os_act_d  [NUM_CH];
    logic             os_shd_q  [NUM_CH];
    logic             os_shd_d  [NUM_CH];
    logic             new_os_s  [NUM_CH];
    logic             wr_s      [NUM_CH];
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] busy_q, busy_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] sq_q, sq_d;

    // Per-channel next-state: config shadowing, FSM, counter and tick.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wr_s[c]      = cfg_we && (cfg_ch == CH_W'(c));
            // A write landing on a load point takes effect immediately.
            new_div_s[c] = wr_s[c] ? cfg_div     : div_shd_q[c];
            new_os_s[c]  = wr_s[c] ? cfg_oneshot : os_shd_q[c];
            div_shd_d[c] = new_div_s[c];
            os_shd_d[c]  = new_os_s[c];
            div_act_d[c] = div_act_q[c];
            os_act_d[c]  = os_act_q[c];
            state_d[c]   = state_q[c];
            cnt_d[c]     = cnt_q[c];
            tick_d[c]    = 1'b0;
            if (!en[c]) begin
                // Disable wins in every state; no period in flight, so load.
                state_d[c]   = ST_IDLE;
                cnt_d[c]     = {CNT_W{1'b0}};
                div_act_d[c] = new_div_s[c];
                os_act_d[c]  = new_os_s[c];
            end else begin
                case (state_q[c])
                    ST_IDLE: begin
                        state_d[c]   = ST_COUNT;
                        cnt_d[c]     = {CNT_W{1'b0}};
                        div_act_d[c] = new_div_s[c];
                        os_act_d[c]  = new_os_s[c];
                    end
                    ST_COUNT: begin
                        if (cnt_q[c] == last_cnt(div_act_q[c])) begin
                            cnt_d[c]     = {CNT_W{1'b0}};
                            tick_d[c]    = 1'b1;
                            state_d[c]   = os_act_q[c] ? ST_DONE : ST_COUNT;
                            div_act_d[c] = new_div_s[c];
                            os_act_d[c]  = new_os_s[c];
                        end else begin
                            cnt_d[c] = cnt_q[c] + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_DONE: begin
                        cnt_d[c]     = {CNT_W{1'b0}};
                        div_act_d[c] = new_div_s[c];
                        os_act_d[c]  = new_os_s[c];
                    end
                    default: begin
                        state_d[c] = ST_IDLE;
                        cnt_d[c]   = {CNT_W{1'b0}};
                    end
                endcase
            end
            busy_d[c] = (state_d[c] == ST_COUNT);
            done_d[c] = (state_d[c] == ST_DONE);
            sq_d[c]   = en[c] ? (sq_q[c] ^ tick_d[c]) : 1'b0;
        end
    end

    // Per-channel state and configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]   <= ST_IDLE;
                cnt_q[c]     <= {CNT_W{1'b0}};
                div_act_q[c] <= DEF_DIV;
                div_shd_q[c] <= DEF_DIV;
                os_act_q[c]  <= 1'b0;
                os_shd_q[c]  <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]   <= state_d[c];
                cnt_q[c]     <= cnt_d[c];
                div_act_q[c] <= div_act_d[c];
                div_shd_q[c] <= div_shd_d[c];
                os_act_q[c]  <= os_act_d[c];
                os_shd_q[c]  <= os_shd_d[c];
            end
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= {NUM_CH{1'b0}};
            busy_q <= {NUM_CH{1'b0}};
            done_q <= {NUM_CH{1'b0}};
        end else begin
            tick_q <= tick_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign tick = tick_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef TICK_PRESCALER_SQ_OUT_EN
    // Square-wave toggle flops, cleared while the channel is disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq_q <= {NUM_CH{1'b0}};
        end else begin
            sq_q <= sq_d;
        end
    end

    assign sq = sq_q;
`else
    // Without the square-wave option the toggle state stays constant.
    always_comb begin
        sq_q = {NUM_CH{1'b0}};
    end
`endif

endmodule

// File: tb/tb_tick_prescaler_mc.sv
// Scoreboard bench for tick_prescaler_mc: a per-channel reference model
// predicts the outputs after every edge; a monitor compares them.
module tb_tick_prescaler_mc;

    localparam int NCH   = 3;
    localparam int CW    = 8;
    localparam int DDIV  = 200;
    localparam int CHW   = 2;

    logic           clk;
    logic           rst;
    logic [NCH-1:0] en;
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_oneshot;
    logic [NCH-1:0] tick, busy, done, sq;

    int errors = 0;
    int checks = 0;

    tick_prescaler_mc #(.CNT_W(CW), .NUM_CH(NCH), .DEFAULT_DIV(DDIV)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_div(cfg_div), .cfg_oneshot(cfg_oneshot),
`ifdef TICK_PRESCALER_SQ_OUT_EN
        .sq(sq),
`endif
        .tick(tick), .busy(busy), .done(done)
    );

`ifndef TICK_PRESCALER_SQ_OUT_EN
    assign sq = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0] tick;
        logic [NCH-1:0] busy;
        logic [NCH-1:0] done;
        logic [NCH-1:0] sq;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: elapsed cycles in the current period, running/finished flags.
    bit running [NCH];
    bit finished[NCH];
    int elapsed [NCH];
    int period  [NCH];
    bit oneshot [NCH];
    int pend_per[NCH];
    bit pend_os [NCH];
    bit sqm     [NCH];

    task automatic chk(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            running[c] = 0; finished[c] = 0; elapsed[c] = 0;
            period[c] = DDIV; oneshot[c] = 0;
            pend_per[c] = DDIV; pend_os[c] = 0; sqm[c] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        exp_t e;
        e = '0;
        for (int c = 0; c < NCH; c++) begin
            bit wr;
            wr = cfg_we && (int'(cfg_ch) == c);
            if (wr) begin
                pend_per[c] = int'(cfg_div);
                pend_os[c]  = cfg_oneshot;
            end
            if (!en[c]) begin
                running[c] = 0; finished[c] = 0; elapsed[c] = 0; sqm[c] = 0;
                period[c] = pend_per[c]; oneshot[c] = pend_os[c];
            end else if (finished[c]) begin
                period[c] = pend_per[c]; oneshot[c] = pend_os[c];
            end else if (!running[c]) begin
                running[c] = 1; elapsed[c] = 0;
                period[c] = pend_per[c]; oneshot[c] = pend_os[c];
            end else begin
                elapsed[c]++;
                if (elapsed[c] >= ((period[c] == 0) ? 1 : period[c])) begin
                    e.tick[c] = 1'b1;
                    sqm[c] = !sqm[c];
                    elapsed[c] = 0;
                    if (oneshot[c]) begin
                        running[c] = 0; finished[c] = 1;
                    end
                    period[c] = pend_per[c]; oneshot[c] = pend_os[c];
                end
            end
            e.busy[c] = running[c];
            e.done[c] = finished[c];
            e.sq[c]   = sqm[c];
        end
        exp_q.push_back(e);
    endtask

    // Monitor: after each edge, pop the prediction and compare outputs.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tick", tick, e.tick);
            chk("busy", busy, e.busy);
            chk("done", done, e.done);
`ifdef TICK_PRESCALER_SQ_OUT_EN
            chk("sq", sq, e.sq);
`endif
        end
    end

    // One clock cycle with the given inputs; called and returns at negedge.
    task automatic cyc(input logic [NCH-1:0] e, input logic w, input logic [CHW-1:0] c,
                       input logic [CW-1:0] d, input logic o);
        en = e; cfg_we = w; cfg_ch = c; cfg_div = d; cfg_oneshot = o;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic run(input logic [NCH-1:0] e, input int n);
        for (int i = 0; i < n; i++) cyc(e, 1'b0, 2'd0, 8'd0, 1'b0);
    endtask

    task automatic reset_mid();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_tick", tick, 3'b000);
        chk("rst_busy", busy, 3'b000);
        chk("rst_done", done, 3'b000);
        chk("rst_sq", sq, 3'b000);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [NCH-1:0] ren;
        rst = 1'b1; en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_oneshot = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("init_busy", busy, 3'b000);
        rst = 1'b0;

        // Reset mid-count, then default divisor after release
        run(3'b001, 6);
        reset_mid();
        run(3'b001, 205);
        run(3'b000, 2);

        // Periodic div=4
        cyc(3'b000, 1'b1, 2'd0, 8'd4, 1'b0);
        run(3'b001, 14);
        run(3'b000, 3);

        // One-shot div=3, disable, re-enable
        cyc(3'b000, 1'b1, 2'd0, 8'd3, 1'b1);
        run(3'b001, 8);
        run(3'b000, 2);
        run(3'b001, 6);
        run(3'b000, 1);

        // Reload while counting, and write coincident with a boundary
        cyc(3'b000, 1'b1, 2'd0, 8'd5, 1'b0);
        run(3'b001, 2);
        cyc(3'b001, 1'b1, 2'd0, 8'd2, 1'b0);
        run(3'b001, 10);
        run(3'b000, 1);
        cyc(3'b000, 1'b1, 2'd0, 8'd4, 1'b0);
        run(3'b001, 4);
        cyc(3'b001, 1'b1, 2'd0, 8'd3, 1'b0);
        run(3'b001, 10);
        run(3'b000, 1);

        // Edge divisors and out-of-range channel
        cyc(3'b000, 1'b1, 2'd0, 8'd0, 1'b0);
        run(3'b001, 5);
        cyc(3'b000, 1'b1, 2'd0, 8'd1, 1'b0);
        run(3'b001, 5);
        run(3'b000, 1);
        cyc(3'b000, 1'b1, 2'd0, 8'd255, 1'b0);
        run(3'b001, 260);
        cyc(3'b001, 1'b1, 2'd3, 8'd9, 1'b1);
        run(3'b001, 5);
        run(3'b000, 1);

        // Two channels with coincident ticks, then rewrite ch1 only
        cyc(3'b000, 1'b1, 2'd0, 8'd3, 1'b0);
        cyc(3'b000, 1'b1, 2'd1, 8'd6, 1'b0);
        run(3'b011, 14);
        cyc(3'b011, 1'b1, 2'd1, 8'd5, 1'b0);
        run(3'b011, 20);
        run(3'b000, 1);

        // Randomized traffic on all channels
        ren = 3'b111;
        for (int i = 0; i < 3000; i++) begin
            logic          w;
            logic [CW-1:0] d;
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 39) == 0) ren[c] = ~ren[c];
            w = ($urandom_range(0, 19) == 0);
            d = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 255)) : CW'($urandom_range(0, 7));
            cyc(ren, w, CHW'($urandom_range(0, 3)), d, ($urandom_range(0, 2) == 0));
        end

        run(3'b000, 2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
